// File: rtl/addsub_pkg.sv
// ----------------------------------------------------------------------------
// addsub_pkg
//   Shared types and constants for the addsub32 sharing arbiter.
//   - ADDSUB_W : datapath width of the shared adder/subtractor.
//   - ID_MAX_W : widest requester id carried in a response (NREQ <= 8).
//   - arb_state_t : sequencer states (idle / settle / respond).
//   - rsp_t : captured result, packed so downstream logic can reuse it.
// ----------------------------------------------------------------------------
package addsub_pkg;

  localparam int ADDSUB_W = 32;
  localparam int ID_MAX_W = 3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_RESP
  } arb_state_t;

  typedef struct packed {
    logic [ADDSUB_W-1:0] sum;
    logic                cout;
    logic                v;
    logic [ID_MAX_W-1:0] id;
  } rsp_t;

endpackage

// File: rtl/addsub32_arbiter_if.sv
// ----------------------------------------------------------------------------
// addsub32_arbiter_if
//   Request/response bundle between NREQ clients and the arbiter.
//   Request side  : req_valid/req_ready handshake per requester, operands
//                   req_a/req_b (slice i = requester i), req_sub (1 = A-B).
//   Response side : rsp_valid/rsp_ready handshake, rsp_id, rsp_sum,
//                   rsp_cout, rsp_v.
//   master : the client side (drives requests, accepts responses).
//   slave  : the arbiter side.
// ----------------------------------------------------------------------------
interface addsub32_arbiter_if
  import addsub_pkg::*;
#(
  parameter int NREQ = 4
);

  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]          req_valid;
  logic [NREQ-1:0]          req_ready;
  logic [NREQ*ADDSUB_W-1:0] req_a;
  logic [NREQ*ADDSUB_W-1:0] req_b;
  logic [NREQ-1:0]          req_sub;

  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [IDW-1:0]           rsp_id;
  logic [ADDSUB_W-1:0]      rsp_sum;
  logic                     rsp_cout;
  logic                     rsp_v;

  modport master (
    output req_valid, req_a, req_b, req_sub, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_v
  );

  modport slave (
    input  req_valid, req_a, req_b, req_sub, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_v
  );

endinterface

// File: rtl/addsub32.sv
// ----------------------------------------------------------------------------
// addsub32
//   Ripple-carry adder/subtractor, purely combinational.
//   a, b : operands      sub : 1 = a - b (a + ~b + 1), 0 = a + b
//   ans  : result        cout : carry out of bit 31
//   v    : signed overflow (carry into bit 31 XOR carry out of bit 31)
// ----------------------------------------------------------------------------
module addsub32
  import addsub_pkg::*;
(
  input  logic [ADDSUB_W-1:0] a,
  input  logic [ADDSUB_W-1:0] b,
  input  logic                sub,
  output logic [ADDSUB_W-1:0] ans,
  output logic                cout,
  output logic                v
);

  logic [ADDSUB_W:0]   c;
  logic [ADDSUB_W-1:0] bx;

  always_comb begin
    // NOTE: every variable gets a value before any branch or loop touches it,
    // so no path leaves it unassigned and no latch is inferred.
    bx   = b ^ {ADDSUB_W{sub}};
    c    = '0;
    ans  = '0;
    c[0] = sub;
    for (int i = 0; i < ADDSUB_W; i++) begin
      ans[i]   = a[i] ^ bx[i] ^ c[i];
      c[i+1]   = (a[i] & bx[i]) | (c[i] & (a[i] ^ bx[i]));
    end
  end

  assign cout = c[ADDSUB_W];
  assign v    = c[ADDSUB_W] ^ c[ADDSUB_W-1];

endmodule

// File: rtl/rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick
//   Round-robin winner selection: first set bit of `valid` at or after `ptr`,
//   wrapping NREQ-1 -> 0.
//   valid : request vector       ptr : highest-priority index this round
//   grant : one-hot winner       idx : winner index
//   any   : at least one request present
// ----------------------------------------------------------------------------
module rr_pick #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         valid,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]         grant,
  output logic [$clog2(NREQ)-1:0] idx,
  output logic                    any
);

  localparam int IDW = $clog2(NREQ);

  logic [IDW-1:0] cand;

  // Walk offsets from farthest to nearest so the nearest valid index after
  // ptr is the last one written and therefore wins.
  always_comb begin
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    grant = '0;
    for (int off = NREQ - 1; off >= 0; off--) begin
      cand = IDW'((int'(ptr) + off) % NREQ);
      if (valid[cand]) begin
        idx = cand;
        any = 1'b1;
      end
    end
    if (any) grant[idx] = 1'b1;
  end

endmodule

// File: rtl/addsub32_arbiter.sv
// ----------------------------------------------------------------------------
// addsub32_arbiter
//   Shares one addsub32 among NREQ requesters. One request is granted at a
//   time; its operands are registered so the ripple path sees stable inputs,
//   the result is captured SETTLE cycles after the grant and presented on a
//   valid/ready response port tagged with the requester id.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : request/response bundle (slave side)
//   NREQ  : requesters, 2..8     SETTLE : grant-to-capture cycles, >= 1
// ----------------------------------------------------------------------------
module addsub32_arbiter
  import addsub_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int SETTLE = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  addsub32_arbiter_if.slave  bus
);

  localparam int IDW = $clog2(NREQ);
  localparam int CW  = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  arb_state_t          state_q, state_d;
  logic [IDW-1:0]      rr_ptr_q;
  logic [IDW-1:0]      cur_id_q;
  logic [CW-1:0]       cnt_q;
  logic [ADDSUB_W-1:0] op_a_q, op_b_q;
  logic                op_sub_q;
  rsp_t                rsp_q;
  logic                rsp_valid_q;

  logic [NREQ-1:0]     win_onehot;
  logic [IDW-1:0]      win_idx;
  logic                win_any;

  logic [ADDSUB_W-1:0] add_ans;
  logic                add_cout, add_v;

  logic                do_grant, do_capture, do_accept;

  rr_pick #(.NREQ(NREQ)) u_rr_pick (
    .valid (bus.req_valid),
    .ptr   (rr_ptr_q),
    .grant (win_onehot),
    .idx   (win_idx),
    .any   (win_any)
  );

  addsub32 u_addsub32 (
    .a    (op_a_q),
    .b    (op_b_q),
    .sub  (op_sub_q),
    .ans  (add_ans),
    .cout (add_cout),
    .v    (add_v)
  );

  // Next-state and handshake decode. req_ready is additionally gated by
  // rst_n so no requester sees an accept while the block is held in reset.
  always_comb begin
    state_d       = state_q;
    do_grant      = 1'b0;
    do_capture    = 1'b0;
    do_accept     = 1'b0;
    bus.req_ready = '0;
    case (state_q)
      S_IDLE: begin
        if (win_any && rst_n) begin
          do_grant      = 1'b1;
          bus.req_ready = win_onehot;
          state_d       = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (cnt_q == '0) begin
          do_capture = 1'b1;
          state_d    = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_valid_q && bus.rsp_ready) begin
          do_accept = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state elements update with non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q    <= '0;
      cur_id_q    <= '0;
      cnt_q       <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_sub_q    <= 1'b0;
      rsp_q       <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      // Operands change only on a grant, so they stay frozen from the grant
      // edge until the response has been taken.
      if (do_grant) begin
        op_a_q   <= bus.req_a[int'(win_idx) * ADDSUB_W +: ADDSUB_W];
        op_b_q   <= bus.req_b[int'(win_idx) * ADDSUB_W +: ADDSUB_W];
        op_sub_q <= bus.req_sub[win_idx];
        cur_id_q <= win_idx;
        cnt_q    <= CW'(SETTLE - 1);
      end

      if (state_q == S_SETTLE && cnt_q != '0) cnt_q <= cnt_q - 1'b1;

      if (do_capture) begin
        rsp_q.sum   <= add_ans;
        rsp_q.cout  <= add_cout;
        rsp_q.v     <= add_v;
        rsp_q.id    <= ID_MAX_W'(cur_id_q);
        rsp_valid_q <= 1'b1;
      end

      // The pointer moves only past the index actually served.
      if (do_accept) begin
        rsp_valid_q <= 1'b0;
        rr_ptr_q    <= (cur_id_q == IDW'(NREQ - 1)) ? '0 : cur_id_q + 1'b1;
      end
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_sum   = rsp_q.sum;
  assign bus.rsp_cout  = rsp_q.cout;
  assign bus.rsp_v     = rsp_q.v;
  assign bus.rsp_id    = rsp_q.id[IDW-1:0];

endmodule

// File: tb/tb_addsub32_arbiter.sv
// ----------------------------------------------------------------------------
// tb_addsub32_arbiter
//   Three arbiters (SETTLE = 2, 1, 3) share one stimulus/observation path;
//   `sel` picks the active one, the others see idle inputs. A behavioural
//   model (round-robin pick from a pointer, response due SETTLE cycles after
//   the grant, signed/unsigned arithmetic for sum/cout/V) checks every cycle.
// ----------------------------------------------------------------------------
module tb_addsub32_arbiter;
  import addsub_pkg::*;

  localparam int N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;
  int   sel = 0;
  int   settle_cur = 2;

  logic [N-1:0]        valid = '0;
  logic [N-1:0]        sub   = '0;
  logic [N-1:0][31:0]  ra    = '0;
  logic [N-1:0][31:0]  rb    = '0;
  logic                rsp_ready = 1'b0;

  logic [N-1:0] o_ready;
  logic         o_valid, o_cout, o_v;
  logic [1:0]   o_id;
  logic [31:0]  o_sum;

  addsub32_arbiter_if #(.NREQ(N)) bus0 ();
  addsub32_arbiter_if #(.NREQ(N)) bus1 ();
  addsub32_arbiter_if #(.NREQ(N)) bus2 ();

  addsub32_arbiter #(.NREQ(N), .SETTLE(2)) dut_s2 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  addsub32_arbiter #(.NREQ(N), .SETTLE(1)) dut_s1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  addsub32_arbiter #(.NREQ(N), .SETTLE(3)) dut_s3 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  assign bus0.req_valid = (sel == 0) ? valid : '0;
  assign bus0.req_a     = ra;
  assign bus0.req_b     = rb;
  assign bus0.req_sub   = sub;
  assign bus0.rsp_ready = (sel == 0) ? rsp_ready : 1'b0;
  assign bus1.req_valid = (sel == 1) ? valid : '0;
  assign bus1.req_a     = ra;
  assign bus1.req_b     = rb;
  assign bus1.req_sub   = sub;
  assign bus1.rsp_ready = (sel == 1) ? rsp_ready : 1'b0;
  assign bus2.req_valid = (sel == 2) ? valid : '0;
  assign bus2.req_a     = ra;
  assign bus2.req_b     = rb;
  assign bus2.req_sub   = sub;
  assign bus2.rsp_ready = (sel == 2) ? rsp_ready : 1'b0;

  always_comb begin
    o_ready = bus0.req_ready; o_valid = bus0.rsp_valid; o_id = bus0.rsp_id;
    o_sum   = bus0.rsp_sum;   o_cout  = bus0.rsp_cout;  o_v  = bus0.rsp_v;
    if (sel == 1) begin
      o_ready = bus1.req_ready; o_valid = bus1.rsp_valid; o_id = bus1.rsp_id;
      o_sum   = bus1.rsp_sum;   o_cout  = bus1.rsp_cout;  o_v  = bus1.rsp_v;
    end else if (sel == 2) begin
      o_ready = bus2.req_ready; o_valid = bus2.rsp_valid; o_id = bus2.rsp_id;
      o_sum   = bus2.rsp_sum;   o_cout  = bus2.rsp_cout;  o_v  = bus2.rsp_v;
    end
  end

  // ---------------------------------------------------------------- checking
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- model
  int          cyc = 0;
  int          n_done = 0;
  bit          m_busy = 0;
  int          m_due = 0;
  int          m_ptr = 0;
  int          m_id = 0;
  logic [31:0] m_sum;
  logic        m_cout, m_v;

  logic [N-1:0] s_ready;
  logic         s_valid, s_cout, s_v;
  logic [1:0]   s_id;
  logic [31:0]  s_sum;

  function automatic logic [33:0] ref_op(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint          sa, sb, r;
    longint unsigned ua, ub;
    logic            c, ov;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    r  = s ? sa - sb : sa + sb;
    ov = (r > 64'sd2147483647) || (r < -64'sd2147483648);
    c  = s ? (a >= b) : ((ua + ub) > 64'h0000_0000_FFFF_FFFF);
    return {ov, c, r[31:0]};
  endfunction

  function automatic int rr_win(input logic [N-1:0] v, input int ptr);
    for (int off = 0; off < N; off++)
      if (v[(ptr + off) % N]) return (ptr + off) % N;
    return -1;
  endfunction

  task automatic model_step();
    int           w;
    logic [N-1:0] exp_ready;
    logic         exp_valid;
    w         = m_busy ? -1 : rr_win(valid, m_ptr);
    exp_ready = '0;
    if (w >= 0) exp_ready[w] = 1'b1;
    check("req_ready", s_ready, exp_ready);
    exp_valid = m_busy && (cyc >= m_due);
    check("rsp_valid", s_valid, exp_valid);
    if (exp_valid) begin
      check("rsp_sum",  s_sum,  m_sum);
      check("rsp_cout", s_cout, m_cout);
      check("rsp_v",    s_v,    m_v);
      check("rsp_id",   s_id,   m_id);
      if (rsp_ready) begin
        m_busy = 0;
        m_ptr  = (m_id + 1) % N;
        n_done++;
      end
    end
    if (w >= 0) begin
      m_busy = 1;
      m_due  = cyc + 1 + settle_cur;
      m_id   = w;
      {m_v, m_cout, m_sum} = ref_op(ra[w], rb[w], sub[w]);
    end
  endtask

  // One clock: sample/check on the falling edge, then return #1 after the
  // rising edge so the caller can drive the next cycle's inputs.
  task automatic cycle();
    @(negedge clk);
    s_ready = o_ready; s_valid = o_valid; s_id = o_id;
    s_sum   = o_sum;   s_cout  = o_cout;  s_v  = o_v;
    if (!rst_n) begin
      check("rst_req_ready", s_ready, '0);
      check("rst_rsp_valid", s_valid, 0);
      check("rst_rsp_sum",   s_sum,   0);
      check("rst_rsp_cout",  s_cout,  0);
      check("rst_rsp_v",     s_v,     0);
      check("rst_rsp_id",    s_id,    0);
      m_busy = 0;
      m_ptr  = 0;
    end else begin
      model_step();
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic do_reset(input int new_sel, input int new_settle);
    rst_n = 1'b0;
    sel = new_sel;
    settle_cur = new_settle;
    for (int k = 0; k < 3; k++) begin
      valid = N'($urandom); sub = N'($urandom); rsp_ready = 1'($urandom);
      for (int i = 0; i < N; i++) begin ra[i] = $urandom; rb[i] = $urandom; end
      cycle();
    end
    valid = '0; rsp_ready = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic dir_op(input string tag, input int idx, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic [31:0] e_sum, input logic e_c, input logic e_v);
    int k;
    bit seen;
    ra[idx] = a; rb[idx] = b; sub[idx] = s; valid[idx] = 1'b1; rsp_ready = 1'b0;
    seen = 0;
    for (k = 0; k < 20 && !seen; k++) begin cycle(); seen = s_ready[idx]; end
    valid[idx] = 1'b0;
    check({tag, "_grant"}, seen, 1);
    seen = 0;
    k = 0;
    while (!seen && k < 20) begin cycle(); k++; seen = s_valid; end
    check({tag, "_latency"}, k, settle_cur + 1);
    check({tag, "_sum"},  s_sum,  e_sum);
    check({tag, "_cout"}, s_cout, e_c);
    check({tag, "_v"},    s_v,    e_v);
    check({tag, "_id"},   s_id,   idx);
    rsp_ready = 1'b1;
    cycle();
    rsp_ready = 1'b0;
  endtask

  task automatic rand_drive();
    for (int i = 0; i < N; i++) begin
      if (s_ready[i] || !valid[i]) begin
        if ($urandom_range(0, 99) < 60) begin
          valid[i] = 1'b1; ra[i] = rand_operand(); rb[i] = rand_operand();
          sub[i] = 1'($urandom_range(0, 1));
        end else begin
          valid[i] = 1'b0;
        end
      end else if ($urandom_range(0, 99) < 5) begin
        valid[i] = 1'b0;
      end
    end
    rsp_ready = ($urandom_range(0, 99) < 60);
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- sequence
  initial begin
    int          ids[$];
    int          k;
    bit          seen;
    logic [31:0] snap_sum;
    logic [1:0]  snap_id;
    logic        snap_c, snap_v;

    // Reset with random inputs, then the first grant goes to the lowest valid.
    do_reset(0, 2);
    ra[2] = 32'd10; rb[2] = 32'd20; sub[2] = 1'b0;
    ra[3] = 32'd1;  rb[3] = 32'd2;  sub[3] = 1'b1;
    valid = 4'b1100;
    cycle();
    check("first_grant", s_ready, 4'b0100);
    valid = 4'b0000; rsp_ready = 1'b1;
    for (int c = 0; c < 6; c++) cycle();
    rsp_ready = 1'b0;

    // Directed arithmetic; pointer walks 3 -> 1 -> 2 -> 3.
    dir_op("add",   0, 32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0008, 1'b0, 1'b0);
    dir_op("subov", 1, 32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
    dir_op("addov", 2, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);

    // Reset one cycle after a grant: the op is dropped and the pointer clears.
    ra[3] = 32'd100; rb[3] = 32'd7; sub[3] = 1'b1; valid = 4'b1000;
    seen = 0;
    for (k = 0; k < 10 && !seen; k++) begin cycle(); seen = s_ready[3]; end
    check("midrst_grant", seen, 1);
    valid = '0;
    cycle();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 6; c++) begin cycle(); seen = seen | s_valid; end
    check("midrst_no_rsp", seen, 0);
    ra[0] = 32'd1; rb[0] = 32'd1; sub[0] = 1'b0; valid = 4'b1001; rsp_ready = 1'b1;
    cycle();
    check("midrst_ptr0", s_ready, 4'b0001);
    ids.delete();
    for (int c = 0; c < 30 && ids.size() < 2; c++) begin
      if (s_ready[0]) valid[0] = 1'b0;
      if (s_ready[3]) valid[3] = 1'b0;
      cycle();
      if (s_valid) ids.push_back(int'(s_id));
    end
    check("midrst_rsp_count", ids.size(), 2);
    if (ids.size() == 2) check("midrst_rerequest_id", ids[1], 3);
    valid = '0; rsp_ready = 1'b0;

    // Fairness with all four requesting continuously and rsp_ready high.
    do_reset(0, 2);
    for (int i = 0; i < N; i++) begin ra[i] = $urandom; rb[i] = $urandom; sub[i] = 1'($urandom); end
    valid = 4'b1111; rsp_ready = 1'b1;
    ids.delete();
    for (int c = 0; c < 60 && ids.size() < 5; c++) begin
      cycle();
      for (int i = 0; i < N; i++)
        if (s_ready[i]) begin ra[i] = $urandom; rb[i] = $urandom; sub[i] = 1'($urandom); end
      if (s_valid) ids.push_back(int'(s_id));
    end
    check("fair_count", ids.size(), 5);
    for (int j = 0; j < ids.size() && j < 5; j++) check("fair_id", ids[j], j % N);

    // Backpressure: rsp_* frozen and no grants while rsp_ready is low.
    rsp_ready = 1'b0;
    seen = 0;
    for (k = 0; k < 20 && !seen; k++) begin cycle(); seen = s_valid; end
    check("hold_rsp_seen", seen, 1);
    snap_sum = s_sum; snap_id = s_id; snap_c = s_cout; snap_v = s_v;
    for (int c = 0; c < 3; c++) begin
      cycle();
      check("hold_valid", s_valid, 1);
      check("hold_sum",   s_sum,   snap_sum);
      check("hold_id",    s_id,    snap_id);
      check("hold_cv",    {s_cout, s_v}, {snap_c, snap_v});
      check("hold_no_grant", s_ready, '0);
    end
    valid = '0; rsp_ready = 1'b1;
    cycle();
    rsp_ready = 1'b0;

    // Random traffic: 2500 ops with SETTLE=1, 2500 with SETTLE=3.
    for (int p = 1; p <= 2; p++) begin
      do_reset(p, (p == 1) ? 1 : 3);
      n_done = 0;
      for (int c = 0; c < 25000 && n_done < 2500; c++) begin
        cycle();
        rand_drive();
      end
      check("rand_ops_done", n_done >= 2500, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/addsub32_arbiter.md
# addsub32_arbiter

Round-robin arbiter and sequencer that shares one `addsub32` ripple adder/subtractor among `NREQ` requesters. It grants one request at a time and registers the operands so the adder input stays stable. It waits a programmable number of clock cycles for the ripple path to settle, then captures sum, carry-out and overflow into a response register with a valid/ready handshake. It sits between client blocks needing 32-bit add/subtract and the single shared `addsub32` instance.

## Interface

- `NREQ`, 4: number of requesters, 2..8.
- `SETTLE`, 2: clock cycles from operand launch to result capture, ≥1.
- `IDW`, `$clog2(NREQ)`: requester id width, derived, not overridable.

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `req_valid` in NREQ: per-requester request valid.
- `req_ready` out NREQ: per-requester accept; at most one bit high.
- `req_a` in NREQ*32: operand A; slice i belongs to requester i.
- `req_b` in NREQ*32: operand B; slice i belongs to requester i.
- `req_sub` in NREQ: 1 = A−B, 0 = A+B.
- `rsp_valid` out 1: result valid.
- `rsp_ready` in 1: consumer accepts result.
- `rsp_id` out IDW: index of the requester that owns the result.
- `rsp_sum` out 32: `addsub32` ans.
- `rsp_cout` out 1: `addsub32` cout.
- `rsp_v` out 1: `addsub32` signed overflow V.

## Operation

- FSM states are IDLE, SETTLE and RESP.
- IDLE: if any `req_valid`, pick the winner as the first valid index at or after `rr_ptr`, wrapping NREQ−1→0.
  - `req_ready[winner]`=1 combinationally in that cycle only. `req_ready` is 0 in all other states.
  - On the edge: latch A/B/SUB into operand registers, latch winner into `cur_id`, load `cnt`=SETTLE−1, go to SETTLE.
- SETTLE: operand registers drive `addsub32`.
  - If `cnt`==0: capture ans/cout/V into the `rsp_*` registers, `rsp_id`=`cur_id`, `rsp_valid`←1, go to RESP.
  - Otherwise decrement `cnt`.
- RESP: hold all `rsp_*` stable while `rsp_ready`=0.
  - On `rsp_valid&&rsp_ready`: `rsp_valid`←0, `rr_ptr`←(`cur_id`+1) mod NREQ, go to IDLE.
- Operand registers are stable from the grant edge through the RESP exit, so the adder never glitches mid-settle.
- Requesters hold valid and operands until ready. Deasserting valid before grant is legal; that requester simply is not served.
- A requester that deasserts never blocks others. The pointer advances only past the served index.
- Arithmetic: SUB=1 computes A+~B+1; cout is the raw carry out of bit 31; V = carry into bit 31 XOR carry out of bit 31. All values come from `addsub32`, with no re-computation in this block.

## Timing

- Reset (async, `rst_n`=0): state=IDLE, `rr_ptr`=0, `cnt`=0, operand regs=0, `cur_id`=0.
  - Outputs: `rsp_valid`=0, `rsp_sum`=0, `rsp_cout`=0, `rsp_v`=0, `rsp_id`=0, `req_ready`=0.
- Grant at edge E0 means `rsp_valid` rises at edge E0+SETTLE (latency SETTLE cycles).
- Response accepted at edge E1 means the next grant occurs no earlier than edge E1+1.
- Maximum throughput: one op per SETTLE+2 cycles.
- Reset mid-operation (SETTLE or RESP): the transaction is dropped, no response is issued, and the requester must re-request.
- A request arriving during SETTLE or RESP waits; it is not queued.
- `rsp_ready` held high: RESP lasts exactly one cycle.
- SETTLE=1: capture on the first SETTLE edge.

## Structure

- Shared package `addsub_pkg`:
  - `ADDSUB_W`=32.
  - FSM state enum `arb_state_t` {IDLE, SETTLE, RESP}.
  - Response struct (sum, cout, v, id) for downstream reuse.
- Sub-module: existing `addsub32`, instantiated once.
- Round-robin selection lives in sub-module `rr_pick` (inputs: valid vector and pointer; outputs: one-hot grant and index).

## Test plan

- Reset: hold `rst_n`=0 with random inputs → all outputs 0, `req_ready`=0; after release, first grant goes to the lowest valid index ≥0.
- Single add, SETTLE=2: req0 A=0x00000005, B=0x00000003, SUB=0 → `req_ready[0]` at E0; at E0+2 `rsp_valid`=1, sum=0x00000008, cout=0, V=0, id=0.
- Overflow cases:
  - req1 A=0x80000000, B=0x00000001, SUB=1 → sum=0x7FFFFFFF, cout=1, V=1.
  - A=0x7FFFFFFF, B=0x00000001, SUB=0 → sum=0x80000000, cout=0, V=1.
- Fairness: all four requesters valid continuously, `rsp_ready`=1 → `rsp_id` sequence 0,1,2,3,0. Holding `rsp_ready`=0 for 3 cycles keeps `rsp_*` unchanged and `req_ready` at 0.
- Reset mid-SETTLE: pulse `rst_n` low one cycle after a grant → no `rsp_valid`; `rr_ptr`=0; the re-requested op completes normally.
- Random: 5000 ops with random A/B/SUB/valid/`rsp_ready`, SETTLE∈{1,3} → every response matches a reference A±B model (sum, cout, V) and is tagged with the correct id.
